// File: rtl/adc_serial_emu_if.sv
// ============================================================================
// Module   : adc_serial_emu_if
// Purpose  : Ready/valid sample stream feeding the ADC serial emulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_serial_emu_if #(
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

`default_nettype wire

// File: rtl/adc_serial_emu.sv
// ============================================================================
// Module   : adc_serial_emu
// Purpose  : 2-lane SDR serial ADC transmitter emulator (frame clock + d1/d0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_serial_emu #(
  parameter int                DATA_W    = 14,
  parameter logic [DATA_W-1:0] RAMP_INIT = '0
) (
  input  wire logic              clk_200m,
  input  wire logic              cpu_resetn,
  input  wire logic              en,
  input  wire logic [1:0]        mode,
  input  wire logic [DATA_W-1:0] fixed_pattern,
  input  wire logic [2:0]        skew,
  adc_serial_emu_if.slave        stream,
  input  wire logic              underrun_clr,
  output logic                   fclk_o,
  output logic                   d0_o,
  output logic                   d1_o,
  output logic                   frame_start_o,
  output logic                   underrun_o
);

  localparam int WORD_W = DATA_W + 2;

  localparam logic [1:0] c_MODE_STREAM = 2'd0;
  localparam logic [1:0] c_MODE_FIXED  = 2'd1;
  localparam logic [1:0] c_MODE_RAMP   = 2'd2;
  localparam logic [1:0] c_MODE_CB     = 2'd3;

  localparam logic [DATA_W-1:0] c_CB_EVEN = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] c_CB_ODD  = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] c_ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [2:0]          r_k;
  logic [2:0]          r_skew;
  logic [WORD_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_ramp;
  logic                r_cb_odd;
  logic [6:0]          r_sh1;
  logic [6:0]          r_sh0;

  logic                w_load;
  logic                w_next_run;
  logic [2:0]          w_k_next;
  logic [2:0]          w_skew_next;
  logic [DATA_W-1:0]   w_sample;
  logic [WORD_W-1:0]   w_word_next;
  logic                w_underrun_set;
  logic [3:0]          w_idx1;
  logic [3:0]          w_idx0;
  logic                w_u1;
  logic                w_u0;
  logic                w_d1;
  logic                w_d0;

  // A load only happens when another frame will follow, so a stream sample
  // is never consumed by a frame that is not transmitted.
  assign w_load         = en && ((r_state == ST_IDLE) || (r_k == 3'd7));
  assign w_next_run     = w_load || ((r_state == ST_RUN) && (r_k != 3'd7));
  assign stream.s_ready = w_load && (mode == c_MODE_STREAM);

  always_comb begin
    w_sample       = r_word[WORD_W-1:2];
    w_underrun_set = 1'b0;
    case (mode)
      c_MODE_STREAM: begin
        if (stream.s_valid) w_sample = stream.s_data;
        else                w_underrun_set = w_load;
      end
      c_MODE_FIXED: w_sample = fixed_pattern;
      c_MODE_RAMP:  w_sample = r_ramp;
      default:      w_sample = r_cb_odd ? c_CB_ODD : c_CB_EVEN;
    endcase
  end

  always_comb begin
    w_word_next = r_word;
    w_skew_next = r_skew;
    w_k_next    = 3'd0;
    if (w_load) begin
      w_word_next = {w_sample, 2'b00};
      w_skew_next = skew;
    end else if ((r_state == ST_RUN) && (r_k != 3'd7)) begin
      w_k_next = r_k + 3'd1;
    end
  end

  // Undelayed lane bits for the cycle about to be presented.
  assign w_idx1 = 4'd15 - {w_k_next, 1'b0};
  assign w_idx0 = 4'd14 - {w_k_next, 1'b0};
  assign w_u1   = w_word_next[w_idx1];
  assign w_u0   = w_word_next[w_idx0];

  // r_sh*[i] holds the undelayed bit from i cycles before the current one.
  always_comb begin
    w_d1 = 1'b0;
    w_d0 = 1'b0;
    if (w_next_run) begin
      if (w_skew_next == 3'd0) begin
        w_d1 = w_u1;
        w_d0 = w_u0;
      end else begin
        w_d1 = r_sh1[w_skew_next - 3'd1];
        w_d0 = r_sh0[w_skew_next - 3'd1];
      end
    end
  end

  always_ff @(posedge clk_200m or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state       <= ST_IDLE;
      r_k           <= 3'd0;
      r_skew        <= 3'd0;
      r_word        <= '0;
      r_ramp        <= RAMP_INIT;
      r_cb_odd      <= 1'b0;
      r_sh1         <= '0;
      r_sh0         <= '0;
      fclk_o        <= 1'b0;
      d0_o          <= 1'b0;
      d1_o          <= 1'b0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      r_state <= w_next_run ? ST_RUN : ST_IDLE;
      r_k     <= w_k_next;
      r_skew  <= w_skew_next;
      r_word  <= w_word_next;

      if (w_load && (mode == c_MODE_RAMP)) r_ramp <= r_ramp + c_ONE;
      if (w_load) r_cb_odd <= (mode == c_MODE_CB) ? ~r_cb_odd : 1'b0;

      // Leaving RUN flushes the delay line so the lanes drop to 0 at once.
      r_sh1 <= w_next_run ? {r_sh1[5:0], w_u1} : '0;
      r_sh0 <= w_next_run ? {r_sh0[5:0], w_u0} : '0;

      fclk_o        <= w_next_run && !w_k_next[2];
      frame_start_o <= w_next_run && (w_k_next == 3'd0);
      d1_o          <= w_d1;
      d0_o          <= w_d0;

      if (w_underrun_set)    underrun_o <= 1'b1;
      else if (underrun_clr) underrun_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_emu.sv
// ============================================================================
// Module   : tb_adc_serial_emu
// Purpose  : Scoreboard bench for adc_serial_emu (frame decode vs. expected).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_serial_emu;

  logic        clk_200m = 1'b0;
  logic        cpu_resetn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd1;
  logic [13:0] fixed_pattern = 14'h0;
  logic [2:0]  skew = 3'd0;
  logic        underrun_clr = 1'b0;
  logic        fclk_o, d0_o, d1_o, frame_start_o, underrun_o;

  adc_serial_emu_if #(.DATA_W(14)) s_if ();

  adc_serial_emu #(.DATA_W(14), .RAMP_INIT(14'h3FF6)) dut (
    .clk_200m      (clk_200m),
    .cpu_resetn    (cpu_resetn),
    .en            (en),
    .mode          (mode),
    .fixed_pattern (fixed_pattern),
    .skew          (skew),
    .stream        (s_if.slave),
    .underrun_clr  (underrun_clr),
    .fclk_o        (fclk_o),
    .d0_o          (d0_o),
    .d1_o          (d1_o),
    .frame_start_o (frame_start_o),
    .underrun_o    (underrun_o)
  );

  always #5 clk_200m = ~clk_200m;

  int          vectors = 0;
  int          miscompares = 0;
  int          cur_skew = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decodes each frame once its last (possibly skewed) bit pair has
  // been presented and compares against the scoreboard head.
  logic [15:0] fs_hist = '0;
  logic [15:0] wsh = '0;
  logic [7:0]  fcsh = '0;
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk_200m);
      if (!cpu_resetn) begin
        fs_hist = '0;
        wsh     = '0;
        fcsh    = '0;
      end else begin
        fs_hist = {fs_hist[14:0], frame_start_o};
        wsh     = {wsh[13:0], d1_o, d0_o};
        fcsh    = {fcsh[6:0], fclk_o};
        if (fs_hist[7] && exp_q.size() > 0)
          check("fclk_pattern", {24'h0, fcsh}, 32'h0000_00F0);
        if (fs_hist[cur_skew + 7] && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_word", {16'h0, wsh}, {16'h0, e, 2'b00});
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk_200m);
      n++;
    end
    if (exp_q.size() > 0) begin
      check({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    @(negedge clk_200m);
    while (!frame_start_o && n < 40) begin
      @(negedge clk_200m);
      n++;
    end
    if (!frame_start_o) check({name, "_fs_timeout"}, 0, 1);
  endtask

  task automatic apply_reset();
    cpu_resetn = 1'b0;
    repeat (2) @(negedge clk_200m);
    cpu_resetn = 1'b1;
  endtask

  task automatic stream_item(input logic [13:0] data, input logic valid);
    int n = 0;
    s_if.s_data  = data;
    s_if.s_valid = valid;
    #1;
    while (!s_if.s_ready && n < 40) begin
      @(negedge clk_200m);
      #1;
      n++;
    end
    if (!s_if.s_ready) check("stream_ready_timeout", 0, 1);
    @(posedge clk_200m);
    #1;
  endtask

  initial begin
    logic       rdy_seen;
    logic [5:0] bits6;
    logic [3:0] idle_or;

    s_if.s_data  = 14'h0;
    s_if.s_valid = 1'b0;

    // Reset state and quiet IDLE after release
    #2;
    check("reset_outputs", {fclk_o, d1_o, d0_o, frame_start_o, underrun_o, s_if.s_ready}, 0);
    @(negedge clk_200m);
    cpu_resetn = 1'b1;
    repeat (3) @(negedge clk_200m);
    check("idle_after_reset", {fclk_o, d1_o, d0_o, frame_start_o, underrun_o}, 0);

    // Mode 1: fixed pattern 0x2A5C, no skew
    mode = 2'd1; fixed_pattern = 14'h2A5C; skew = 3'd0; cur_skew = 0;
    repeat (3) exp_q.push_back(14'h2A5C);
    en = 1'b1;
    rdy_seen = 1'b0;
    repeat (16) begin
      @(negedge clk_200m);
      rdy_seen = rdy_seen | s_if.s_ready;
    end
    check("s_ready_in_fixed_mode", {31'h0, rdy_seen}, 0);
    drain("fixed");

    // Asynchronous reset in the middle of a frame
    wait_fs("async_rst");
    #1 cpu_resetn = 1'b0;
    #1 check("async_reset_outputs", {fclk_o, d1_o, d0_o, frame_start_o, underrun_o}, 0);
    en = 1'b0;
    repeat (2) @(negedge clk_200m);
    cpu_resetn = 1'b1;

    // Mode 2: ramp preset near wrap, 20 frames across 0x3FFF -> 0x0000
    mode = 2'd2;
    for (int i = 0; i < 20; i++) exp_q.push_back(14'(14'h3FF6 + i));
    @(negedge clk_200m);
    en = 1'b1;
    drain("ramp");
    en = 1'b0;
    repeat (12) @(negedge clk_200m);

    // Mode 0: stream with one missing sample
    mode = 2'd0;
    exp_q.push_back(14'h0111);
    exp_q.push_back(14'h0222);
    exp_q.push_back(14'h0222);
    exp_q.push_back(14'h0333);
    en = 1'b1;
    stream_item(14'h0111, 1'b1);
    stream_item(14'h0222, 1'b1);
    check("underrun_before_gap", {31'h0, underrun_o}, 0);
    stream_item(14'h3FFF, 1'b0);
    check("underrun_after_gap", {31'h0, underrun_o}, 1);
    stream_item(14'h0333, 1'b1);
    en = 1'b0;
    s_if.s_valid = 1'b0;
    check("underrun_sticky", {31'h0, underrun_o}, 1);
    @(negedge clk_200m);
    underrun_clr = 1'b1;
    @(negedge clk_200m);
    underrun_clr = 1'b0;
    check("underrun_cleared", {31'h0, underrun_o}, 0);
    drain("stream");
    repeat (12) @(negedge clk_200m);

    // Mode 3 with skew 3
    mode = 2'd3; skew = 3'd3; cur_skew = 3;
    exp_q.push_back(14'h2AAA);
    exp_q.push_back(14'h1555);
    exp_q.push_back(14'h2AAA);
    exp_q.push_back(14'h1555);
    en = 1'b1;
    wait_fs("skew");
    bits6 = {4'h0, d1_o, d0_o};
    @(negedge clk_200m);
    bits6 = {bits6[3:0], d1_o, d0_o};
    @(negedge clk_200m);
    bits6 = {bits6[3:0], d1_o, d0_o};
    check("skew_leading_zeros", {26'h0, bits6}, 0);
    @(negedge clk_200m);
    check("skew_first_bit", {30'h0, d1_o, d0_o}, 2);
    drain("skew");
    en = 1'b0;
    apply_reset();
    skew = 3'd0; cur_skew = 0;

    // en dropped at k = 2, frame completes, then restart
    mode = 2'd1; fixed_pattern = 14'h2A5C;
    exp_q.push_back(14'h2A5C);
    en = 1'b1;
    wait_fs("en_drop");
    @(negedge clk_200m);
    @(negedge clk_200m);
    en = 1'b0;
    bits6 = '0;
    repeat (6) begin
      @(negedge clk_200m);
      bits6 = {bits6[4:0], fclk_o};
    end
    check("en_drop_fclk_tail", {26'h0, bits6}, 32'h20);
    drain("en_drop");
    idle_or = '0;
    repeat (4) begin
      @(negedge clk_200m);
      idle_or = idle_or | {fclk_o, d1_o, d0_o, frame_start_o};
    end
    check("idle_after_en_drop", {28'h0, idle_or}, 0);
    exp_q.push_back(14'h2A5C);
    en = 1'b1;
    @(negedge clk_200m);
    check("restart_frame_start", {30'h0, frame_start_o, fclk_o}, 3);
    drain("restart");
    en = 1'b0;
    repeat (10) @(negedge clk_200m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
